// File: rtl/lcd_cfah_ctrl.sv
// lcd_cfah_ctrl: CFAH 8-bit character-LCD bus initiator with E-strobe timing and busy-flag polling.
module lcd_cfah_ctrl #(
  parameter int G_T_AS        = 4,
  parameter int G_T_PWEH      = 25,
  parameter int G_T_AH        = 2,
  parameter int G_T_CYCLE     = 50,
  parameter int G_BF_POLL_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_valid,
  input  logic       i_cmd_rs,
  input  logic       i_cmd_rw,
  input  logic       i_cmd_skip_bf,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_ready,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_rdata_val,
  output logic       o_bf_timeout,
  output logic       o_rs,
  output logic       o_rw,
  output logic       o_en,
  inout  wire  [7:0] io_data
);
  typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, HOLD, BF_SETUP, BF_EN_HIGH, BF_HOLD, DONE} state_t;
  state_t      state_q;
  logic [15:0] cnt_q, rise_q;
  logic [7:0]  poll_q, data_q, smp_q, rdata_q;
  logic        rs_q, rw_q, en_q, ready_q, done_q, rval_q, tmo_q, skip_q, free_q;
  logic        as_ok, pw_end, ah_end;
  // free_q lifts the rise-to-rise constraint for the first E pulse after reset
  assign as_ok  = cnt_q >= 16'(G_T_AS - 1) && (free_q || rise_q >= 16'(G_T_CYCLE));
  assign pw_end = cnt_q == 16'(G_T_PWEH - 1);
  assign ah_end = cnt_q == 16'(G_T_AH - 1);
  assign io_data      = rw_q ? 8'hzz : data_q;
  assign o_cmd_ready  = ready_q;
  assign o_done       = done_q;
  assign o_rdata      = rdata_q;
  assign o_rdata_val  = rval_q;
  assign o_bf_timeout = tmo_q;
  assign o_rs         = rs_q;
  assign o_rw         = rw_q;
  assign o_en         = en_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rise_q  <= '0;
      poll_q  <= '0;
      data_q  <= '0;
      smp_q   <= '0;
      rdata_q <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      rval_q  <= 1'b0;
      tmo_q   <= 1'b0;
      skip_q  <= 1'b0;
      free_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      rval_q <= 1'b0;
      tmo_q  <= 1'b0;
      cnt_q  <= cnt_q + 16'd1;
      rise_q <= rise_q < 16'(G_T_CYCLE) ? rise_q + 16'd1 : rise_q;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          poll_q <= '0;
          if (i_cmd_valid && ready_q) begin
            ready_q <= 1'b0;
            rs_q    <= i_cmd_rs;
            rw_q    <= i_cmd_rw;
            skip_q  <= i_cmd_skip_bf;
            data_q  <= i_cmd_data;
            state_q <= SETUP;
          end else ready_q <= 1'b1;
        end
        SETUP, BF_SETUP: if (as_ok) begin
          state_q <= state_q == SETUP ? EN_HIGH : BF_EN_HIGH;
          en_q    <= 1'b1;
          cnt_q   <= '0;
          rise_q  <= 16'd1;
          free_q  <= 1'b0;
        end
        EN_HIGH, BF_EN_HIGH: if (pw_end) begin
          smp_q   <= io_data;
          en_q    <= 1'b0;
          cnt_q   <= '0;
          poll_q  <= state_q == BF_EN_HIGH ? poll_q + 8'd1 : poll_q;
          state_q <= state_q == EN_HIGH ? HOLD : BF_HOLD;
        end
        HOLD: if (ah_end) begin
          cnt_q <= '0;
          if (rw_q || skip_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            rval_q  <= rw_q;
            rdata_q <= rw_q ? smp_q : rdata_q;
          end else begin
            state_q <= BF_SETUP;
            rs_q    <= 1'b0;
            rw_q    <= 1'b1;
          end
        end
        BF_HOLD: if (ah_end) begin
          cnt_q <= '0;
          if (!smp_q[7] || poll_q >= 8'(G_BF_POLL_MAX)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            tmo_q   <= smp_q[7];
          end else state_q <= BF_SETUP;
        end
        default: begin
          state_q <= IDLE;
          rw_q    <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_cfah_ctrl.sv
// tb_lcd_cfah_ctrl: directed bench for lcd_cfah_ctrl with a small CFAH LCD responder model.
module tb_lcd_cfah_ctrl;
  timeunit 1ns;
  timeprecision 1ps;
  logic clk = 0, rst_n = 0, sel = 0;
  logic v0 = 0, v1 = 0, crs = 0, crw = 0, cskip = 0;
  logic [7:0] cdata = 0;
  logic ready0, done0, rval0, tmo0, rs0, rw0, en0;
  logic ready1, done1, rval1, tmo1, rs1, rw1, en1;
  logic [7:0] rdata0, rdata1;
  wire  [7:0] io0, io1;
  always #5 clk = ~clk;
  lcd_cfah_ctrl dut0 (.clk(clk), .rst_n(rst_n), .i_cmd_valid(v0), .i_cmd_rs(crs), .i_cmd_rw(crw),
    .i_cmd_skip_bf(cskip), .i_cmd_data(cdata), .o_cmd_ready(ready0), .o_done(done0), .o_rdata(rdata0),
    .o_rdata_val(rval0), .o_bf_timeout(tmo0), .o_rs(rs0), .o_rw(rw0), .o_en(en0), .io_data(io0));
  lcd_cfah_ctrl #(.G_BF_POLL_MAX(3)) dut1 (.clk(clk), .rst_n(rst_n), .i_cmd_valid(v1), .i_cmd_rs(crs),
    .i_cmd_rw(crw), .i_cmd_skip_bf(cskip), .i_cmd_data(cdata), .o_cmd_ready(ready1), .o_done(done1),
    .o_rdata(rdata1), .o_rdata_val(rval1), .o_bf_timeout(tmo1), .o_rs(rs1), .o_rw(rw1), .o_en(en1),
    .io_data(io1));
  logic m_ready, m_done, m_rval, m_tmo, m_rs, m_rw, m_en;
  logic [7:0] m_rdata, m_db, resp, rd_byte = 0, last_wr = 0;
  logic [6:0] ac = 0;
  logic [7:0] ddram [8];
  logic stuck = 0, last_rs = 0;
  int busy_left = 0;
  assign m_ready = sel ? ready1 : ready0;
  assign m_done  = sel ? done1 : done0;
  assign m_rval  = sel ? rval1 : rval0;
  assign m_tmo   = sel ? tmo1 : tmo0;
  assign m_rdata = sel ? rdata1 : rdata0;
  assign m_rs    = sel ? rs1 : rs0;
  assign m_rw    = sel ? rw1 : rw0;
  assign m_en    = sel ? en1 : en0;
  assign m_db    = sel ? io1 : io0;
  assign resp    = !m_rs ? {stuck || busy_left != 0, ac} : rd_byte;
  assign io0     = (!sel && rw0) ? resp : 8'hzz;
  assign io1     = (sel && rw1) ? resp : 8'hzz;
  int cyc = 0, errors = 0, checks = 0, acc_cyc = 0;
  int rise_n, last_rise, sp_min, sp_max, pw_cnt = 0, pw_last = 0, fall_cyc = 0, stab = 0, stab_rise = 0;
  int hold_min, viol, done_n = 0, done_cyc = 0, bf_reads, wr_n = 0, stray = 0;
  logic d_rval = 0, d_tmo = 0, hold_pend = 0, en_prev = 0;
  logic [7:0] d_rdata = 0;
  logic [9:0] bus, bus_prev = 0;
  // Monitor and LCD model, sampled 1 ns after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    bus = {m_rs, m_rw, m_rw ? 8'h00 : m_db};
    if (bus != bus_prev) begin
      if (m_en && en_prev) viol++;
      if (hold_pend && !m_en && cyc - fall_cyc < hold_min) hold_min = cyc - fall_cyc;
      hold_pend = 0;
      stab = 0;
    end else stab++;
    if (m_en && !en_prev) begin
      rise_n++;
      if (last_rise >= 0) begin
        if (cyc - last_rise < sp_min) sp_min = cyc - last_rise;
        if (cyc - last_rise > sp_max) sp_max = cyc - last_rise;
      end
      last_rise = cyc;
      stab_rise = stab;
      pw_cnt = 0;
    end
    if (m_en) pw_cnt++;
    if (!m_en && en_prev) begin
      pw_last = pw_cnt;
      fall_cyc = cyc;
      hold_pend = 1;
      if (m_rw && !m_rs) begin
        bf_reads++;
        if (busy_left > 0) busy_left--;
      end else if (!m_rw) begin
        wr_n++;
        last_wr = m_db;
        last_rs = m_rs;
        if (m_rs) begin
          ddram[ac[2:0]] = m_db;
          ac++;
        end else if (m_db[7]) ac = m_db[6:0];
      end
    end
    if (m_done) begin
      done_n++;
      done_cyc = cyc;
      d_rval = m_rval;
      d_tmo = m_tmo;
      d_rdata = m_rdata;
    end
    if ((m_rval || m_tmo) && !m_done) stray++;
    en_prev = m_en;
    bus_prev = bus;
  end
  task automatic clr();
    rise_n = 0; last_rise = -1; sp_min = 1000000; sp_max = 0; hold_min = 1000000; viol = 0; bf_reads = 0;
  endtask
  task automatic run_cmd(input logic rs, input logic rw, input logic skip, input logic [7:0] d);
    int t = 0, n0 = done_n;
    while (!m_ready && t < 300) begin @(negedge clk); t++; end
    checks++;
    if (!m_ready) begin errors++; $display("FAIL ready_wait: ready=%b required 1", m_ready); end
    crs = rs; crw = rw; cskip = skip; cdata = d;
    if (sel) v1 = 1; else v0 = 1;
    @(negedge clk);
    acc_cyc = cyc;
    v0 = 0; v1 = 0;
    t = 0;
    while (done_n == n0 && t < 3000) begin @(negedge clk); t++; end
    checks++;
    if (done_n == n0) begin errors++; $display("FAIL done_wait: no o_done within %0d cycles", t); end
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready0, en0, rw0, rs0, done0, rval0, tmo0} !== 7'b0010000 || rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: rdy/en/rw/rs/done/rval/tmo=%b rdata=%h required 0010000 00",
               {ready0, en0, rw0, rs0, done0, rval0, tmo0}, rdata0);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready: ready=%b required 1", ready0); end
  endtask
  task automatic test_write_skip();
    clr();
    run_cmd(0, 0, 1, 8'h38);
    checks++;
    if (pw_last != 25) begin errors++; $display("FAIL wr_pweh: E high %0d required 25", pw_last); end
    checks++;
    if (stab_rise != 4) begin errors++; $display("FAIL wr_setup: bus stable %0d required 4", stab_rise); end
    checks++;
    if (last_rise - acc_cyc != 4) begin errors++; $display("FAIL wr_first_rise: %0d required 4", last_rise - acc_cyc); end
    checks++;
    if (done_cyc - fall_cyc != 2) begin errors++; $display("FAIL wr_hold_done: %0d required 2", done_cyc - fall_cyc); end
    checks++;
    if (last_wr !== 8'h38 || last_rs !== 1'b0) begin
      errors++; $display("FAIL wr_log: data=%h rs=%b required 38 0", last_wr, last_rs);
    end
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1 || hold_min < 2) begin
      errors++; $display("FAIL wr_ready_after: ready=%b hold=%0d required 1 >=2", m_ready, hold_min);
    end
  endtask
  task automatic test_bf_poll();
    run_cmd(0, 0, 1, 8'h80);
    clr();
    busy_left = 3;
    run_cmd(1, 0, 0, 8'h41);
    checks++;
    if (bf_reads != 4) begin errors++; $display("FAIL bf_reads: %0d required 4", bf_reads); end
    checks++;
    if (sp_min != 50 || sp_max != 50 || rise_n != 5) begin
      errors++; $display("FAIL bf_spacing: min=%0d max=%0d rises=%0d required 50 50 5", sp_min, sp_max, rise_n);
    end
    checks++;
    if (d_tmo !== 1'b0) begin errors++; $display("FAIL bf_tmo: %b required 0", d_tmo); end
    checks++;
    if (ddram[0] !== 8'h41 || last_rs !== 1'b1 || ac != 7'd1) begin
      errors++; $display("FAIL bf_ddram: ddram0=%h rs=%b ac=%h required 41 1 01", ddram[0], last_rs, ac);
    end
    checks++;
    if (hold_min != 2) begin errors++; $display("FAIL bf_hold: %0d required 2", hold_min); end
  endtask
  task automatic test_back_to_back();
    int t = 0, n0 = done_n, w0 = wr_n;
    clr();
    crs = 0; crw = 0; cskip = 1; cdata = 8'h80; v0 = 1;
    @(negedge clk);
    while (m_ready && t < 300) begin @(negedge clk); t++; end
    cdata = 8'h48;
    while (done_n == n0 && t < 3000) begin @(negedge clk); t++; end
    while (!m_ready && t < 3000) begin @(negedge clk); t++; end
    @(negedge clk);
    v0 = 0;
    while (done_n < n0 + 2 && t < 6000) begin @(negedge clk); t++; end
    checks++;
    if (done_n != n0 + 2) begin errors++; $display("FAIL b2b_done: %0d dones required 2", done_n - n0); end
    checks++;
    if (sp_min != 50 || rise_n != 2) begin
      errors++; $display("FAIL b2b_spacing: min=%0d rises=%0d required 50 2", sp_min, rise_n);
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL b2b_stable: %0d bus changes while E=1 required 0", viol); end
    checks++;
    if (last_wr !== 8'h48 || wr_n - w0 != 2) begin
      errors++; $display("FAIL b2b_log: last=%h writes=%0d required 48 2", last_wr, wr_n - w0);
    end
  endtask
  task automatic test_read();
    rd_byte = 8'h5A;
    clr();
    run_cmd(1, 1, 0, 8'h00);
    checks++;
    if (d_rdata !== 8'h5A || d_rval !== 1'b1) begin
      errors++; $display("FAIL rd_data: rdata=%h val=%b required 5a 1", d_rdata, d_rval);
    end
    checks++;
    if (bf_reads != 0 || rise_n != 1) begin
      errors++; $display("FAIL rd_nopoll: bf_reads=%0d rises=%0d required 0 1", bf_reads, rise_n);
    end
    run_cmd(0, 0, 1, 8'h85);
    run_cmd(0, 1, 0, 8'h00);
    checks++;
    if (d_rdata !== 8'h05 || d_rval !== 1'b1) begin
      errors++; $display("FAIL rd_bfac: rdata=%h val=%b required 05 1", d_rdata, d_rval);
    end
  endtask
  task automatic test_timeout();
    sel = 1;
    stuck = 1;
    clr();
    run_cmd(0, 0, 0, 8'h20);
    checks++;
    if (bf_reads != 3) begin errors++; $display("FAIL tmo_reads: %0d required 3", bf_reads); end
    checks++;
    if (d_tmo !== 1'b1 || d_rval !== 1'b0) begin
      errors++; $display("FAIL tmo_flag: tmo=%b val=%b required 1 0", d_tmo, d_rval);
    end
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1) begin errors++; $display("FAIL tmo_idle: ready=%b required 1", m_ready); end
    stuck = 0;
    sel = 0;
  endtask
  task automatic test_reset_abort();
    int t = 0, n0;
    clr();
    while (!m_ready && t < 300) begin @(negedge clk); t++; end
    crs = 0; crw = 0; cskip = 0; cdata = 8'h01; v0 = 1;
    @(negedge clk);
    v0 = 0;
    while (!m_en && t < 300) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    n0 = done_n;
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (en0 !== 1'b0 || rw0 !== 1'b1 || ready0 !== 1'b0) begin
      errors++; $display("FAIL abort_bus: en=%b rw=%b ready=%b required 0 1 0", en0, rw0, ready0);
    end
    rst_n = 1;
    repeat (40) @(negedge clk);
    checks++;
    if (done_n != n0 || ready0 !== 1'b1 || rdata0 !== 8'h00) begin
      errors++; $display("FAIL abort_after: dones=%0d ready=%b rdata=%h required 0 1 00", done_n - n0, ready0, rdata0);
    end
    clr();
    run_cmd(0, 0, 1, 8'h0C);
    checks++;
    if (last_rise - acc_cyc != 4 || pw_last != 25) begin
      errors++; $display("FAIL abort_next: rise=%0d pw=%0d required 4 25", last_rise - acc_cyc, pw_last);
    end
  endtask
  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    clr();
    test_reset();
    test_write_skip();
    test_bf_poll();
    test_back_to_back();
    test_read();
    test_timeout();
    test_reset_abort();
    checks++;
    if (stray != 0) begin errors++; $display("FAIL stray_pulse: %0d required 0", stray); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
